rowbuffer_ctrl: RTL
===================

ROWBUFFER_CTRL -- requirements
Module: rowbuffer_ctrl

Interface
REQ-001 SHALL have parameter dataWidth, default 32: bits per feature element.
REQ-002 SHALL have parameter pvadd, default 128: elements per row.
REQ-003 SHALL have parameter k, default 1024: rows per bank; addressWidth = clog2(k); rowWidth = dataWidth*pvadd.
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- inValid  in  1  write-side row valid.
- inReady  out  1  write-side row accepted when inValid&inReady.
- inData  in  rowWidth  row to store.
- inLast  in  1  row is the final row of its block.
- outValid  out  1  read-side row valid.
- outReady  in  1  downstream accepts row.
- outData  out  rowWidth  row read back.
- outLast  out  1  final row of a drained block.
- enableA, enableB  out  1  bank A/B memory enable.
- writeEnableA1, writeEnableB1  out  1  port-1 write enable, bank A/B.
- addressportA1, addressportB1  out  addressWidth  port-1 (write) address.
- writeportA1, writeportB1  out  rowWidth  port-1 write data.
- addressportA2, addressportB2  out  addressWidth  port-2 (read) address.
- readportA2, readportB2  in  rowWidth  port-2 read data, 2-cycle latency.
REQ-005 SHALL require the integrator to tie rowbuffer port-2 write enables low and port-1 read data unused.

Function
REQ-006 SHALL keep per bank a state: EMPTY, FILLING, FULL, DRAINING, plus a row count (addressWidth+1 bits).
REQ-007 SHALL fill banks strictly alternating A, B, A, ...; drain in the same order, starting with A.
REQ-008 SHALL assert inReady iff the current fill bank is EMPTY or FILLING.
REQ-009 On each accepted row, SHALL write inData at the fill pointer in that bank the same cycle (enable and writeEnable high), then increment the pointer.
REQ-010 Bank SHALL go FULL, recording count = pointer+1, when the accepted row has inLast=1 or the pointer equals k-1 (both together: one transition); fill pointer resets to 0 and fill target toggles.
REQ-011 A FULL bank at the drain target SHALL go DRAINING the next cycle.
REQ-012 SHALL issue reads at addresses 0..count-1 in order, at most one per cycle, driving enable high and writeEnable low.
REQ-013 SHALL hold a 4-entry output FIFO; a read is issued only when FIFO occupancy plus in-flight reads is below 4, so data is never dropped.
REQ-014 SHALL capture readport data exactly 2 cycles after issue into the FIFO, with a last flag set for address count-1.
REQ-015 outValid = FIFO non-empty; outData/outLast = FIFO head; pop on outValid&outReady.
REQ-016 Read data SHALL be identical to written data, in write order, with no gaps or duplicates.
REQ-017 With outReady held high, SHALL sustain one row per cycle after a 3-cycle initial latency (FULL to first outValid).
REQ-018 Bank SHALL return to EMPTY only when the data of its last read is captured, not at issue; drain target then toggles.
REQ-019 Simultaneous fill of one bank and drain of the other SHALL proceed at full rate with no interference.
REQ-020 enable SHALL be low on cycles with neither a write nor a read to that bank.

Reset
REQ-021 While rst=0: both banks EMPTY, pointers/counts 0, fill and drain targets A, FIFO empty, in-flight cleared; inReady=0, outValid=0, outLast=0, all enables and write enables 0, addresses and writeport 0.
REQ-022 inReady SHALL rise on the first clk edge after rst deasserts; reset mid-transfer discards all buffered and in-flight rows.

Verification
REQ-023 k=8: write 8 rows 1..8, no inLast, outReady=1 -> bank A FULL; out 1..8, outLast on 8, first outValid 3 cycles after FULL.
REQ-024 k=8: write 3 rows, inLast on row 3 -> count=3; out 3 rows, outLast on third; next write goes to bank B.
REQ-025 k=8, outReady=0: write 16 rows -> inReady low after row 16; FIFO holds 4; release outReady -> 16 rows in order, then inReady high.
REQ-026 Random outReady (50%) with continuous writes of 40 rows, inLast every 5 -> output equals input, outLast every 5th row.
REQ-027 Assert rst during draining with 2 reads in flight -> outValid 0 immediately; after release no stale row appears, inReady=1.

Source files
------------

// File: rtl/rowbuffer_ctrl.sv
// Ping-pong row buffer: fills two external dual-port banks alternately and drains them
// in the same order through a small output FIFO that absorbs the 2-cycle read latency.
module rowbuffer_ctrl #(
    parameter int dataWidth = 32,
    parameter int pvadd     = 128,
    parameter int k         = 1024,
    localparam int addressWidth = $clog2(k),
    localparam int rowWidth     = dataWidth * pvadd
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [rowWidth-1:0]     inData,
    input  logic                    inLast,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [rowWidth-1:0]     outData,
    output logic                    outLast,
    output logic                    enableA,
    output logic                    enableB,
    output logic                    writeEnableA1,
    output logic                    writeEnableB1,
    output logic [addressWidth-1:0] addressportA1,
    output logic [addressWidth-1:0] addressportB1,
    output logic [rowWidth-1:0]     writeportA1,
    output logic [rowWidth-1:0]     writeportB1,
    output logic [addressWidth-1:0] addressportA2,
    output logic [addressWidth-1:0] addressportB2,
    input  logic [rowWidth-1:0]     readportA2,
    input  logic [rowWidth-1:0]     readportB2
);

    localparam int countWidth = addressWidth + 1;
    localparam logic [addressWidth-1:0] lastAddr = addressWidth'(k - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bankState_t;

    bankState_t              bankState     [2];
    bankState_t              bankStateNext [2];
    logic [countWidth-1:0]   bankCount     [2];
    logic [countWidth-1:0]   bankCountNext [2];
    logic                    fillSel, fillSelNext;
    logic                    drainSel, drainSelNext;
    logic [addressWidth-1:0] fillPtr, fillPtrNext;
    logic [countWidth-1:0]   readPtr, readPtrNext;
    logic                    runReg;
    logic [1:0]              pipeValid, pipeLast;

    logic [rowWidth-1:0]     fifoData [4];
    logic                    fifoLast [4];
    logic [1:0]              fifoWrPtr, fifoRdPtr;
    logic [2:0]              fifoCount;

    logic                    fillOpen, writeFire, fillEnd;
    logic                    drainActive, readFire, issueLast;
    logic                    capture, captureLast, pop;
    logic [2:0]              inFlight;
    logic [countWidth-1:0]   drainCount;
    logic [rowWidth-1:0]     readData;
    logic                    writeA, writeB, readA, readB;

    assign fillOpen  = (bankState[fillSel] == EMPTY) || (bankState[fillSel] == FILLING);
    assign inReady   = runReg && fillOpen;
    assign writeFire = inValid && inReady;
    assign fillEnd   = writeFire && (inLast || (fillPtr == lastAddr));

    // Reads start in the cycle the bank is seen FULL so the first row emerges 3 cycles later.
    assign drainCount  = bankCount[drainSel];
    assign drainActive = (bankState[drainSel] == FULL) || (bankState[drainSel] == DRAINING);
    assign inFlight    = 3'(pipeValid[0]) + 3'(pipeValid[1]);
    assign readFire    = drainActive && (readPtr < drainCount) && ((fifoCount + inFlight) < 3'd4);
    assign issueLast   = readFire && (readPtr == (drainCount - countWidth'(1)));

    assign capture     = pipeValid[1];
    assign captureLast = capture && pipeLast[1];
    assign readData    = drainSel ? readportB2 : readportA2;
    assign pop         = outValid && outReady;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bankStateNext[b] = bankState[b];
            bankCountNext[b] = bankCount[b];
        end
        fillPtrNext  = fillPtr;
        fillSelNext  = fillSel;
        drainSelNext = drainSel;
        readPtrNext  = readPtr;

        if (writeFire) begin
            if (fillEnd) begin
                bankStateNext[fillSel] = FULL;
                bankCountNext[fillSel] = {1'b0, fillPtr} + countWidth'(1);
                fillPtrNext            = '0;
                fillSelNext            = ~fillSel;
            end else begin
                bankStateNext[fillSel] = FILLING;
                fillPtrNext            = fillPtr + addressWidth'(1);
            end
        end

        if (bankState[drainSel] == FULL) begin
            bankStateNext[drainSel] = DRAINING;
        end
        if (readFire) begin
            readPtrNext = readPtr + countWidth'(1);
        end
        // The bank is released only once its final row has landed in the FIFO.
        if (captureLast) begin
            bankStateNext[drainSel] = EMPTY;
            bankCountNext[drainSel] = '0;
            drainSelNext            = ~drainSel;
            readPtrNext             = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                bankState[b] <= EMPTY;
                bankCount[b] <= '0;
            end
            fillSel   <= 1'b0;
            drainSel  <= 1'b0;
            fillPtr   <= '0;
            readPtr   <= '0;
            runReg    <= 1'b0;
            pipeValid <= '0;
            pipeLast  <= '0;
            fifoWrPtr <= '0;
            fifoRdPtr <= '0;
            fifoCount <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bankState[b] <= bankStateNext[b];
                bankCount[b] <= bankCountNext[b];
            end
            fillSel   <= fillSelNext;
            drainSel  <= drainSelNext;
            fillPtr   <= fillPtrNext;
            readPtr   <= readPtrNext;
            runReg    <= 1'b1;
            pipeValid <= {pipeValid[0], readFire};
            pipeLast  <= {pipeLast[0], issueLast};
            if (capture) begin
                fifoWrPtr <= fifoWrPtr + 2'd1;
            end
            if (pop) begin
                fifoRdPtr <= fifoRdPtr + 2'd1;
            end
            fifoCount <= fifoCount + 3'(capture) - 3'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            fifoData[fifoWrPtr] <= readData;
            fifoLast[fifoWrPtr] <= pipeLast[1];
        end
    end

    assign outValid = (fifoCount != 3'd0);
    assign outData  = outValid ? fifoData[fifoRdPtr] : '0;
    assign outLast  = outValid && fifoLast[fifoRdPtr];

    assign writeA = writeFire && !fillSel;
    assign writeB = writeFire && fillSel;
    assign readA  = readFire && !drainSel;
    assign readB  = readFire && drainSel;

    assign enableA       = writeA || readA;
    assign enableB       = writeB || readB;
    assign writeEnableA1 = writeA;
    assign writeEnableB1 = writeB;
    assign addressportA1 = writeA ? fillPtr : '0;
    assign addressportB1 = writeB ? fillPtr : '0;
    assign writeportA1   = writeA ? inData : '0;
    assign writeportB1   = writeB ? inData : '0;
    assign addressportA2 = readA ? readPtr[addressWidth-1:0] : '0;
    assign addressportB2 = readB ? readPtr[addressWidth-1:0] : '0;

endmodule
